// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: synchronises rxin, finds the start bit with
// OS_RATE oversampling, samples mid-bit and delivers the word plus error flags.
module uart_rx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rxin,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 busy,
  output logic                 shift_en,
  output logic                 sample_bit,
  output logic                 checkparity,
  output logic                 checkstop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic [2:0]           state_dbg
);

  localparam int OSW = $clog2(OS_RATE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_HALF  = OSW'(OS_RATE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OS_RATE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rxs;
  logic                 rxs_d;
  logic [OSW-1:0]       os_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 par_err_q;
  logic                 par_en_q;
  logic                 par_odd_q;

  // Synchroniser flops reset high so release from reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rxin;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      par_err_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      shift_en     <= 1'b0;
      sample_bit   <= 1'b0;
      rx_data      <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      shift_en   <= 1'b0;
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // Edge search runs every clk; a tick on the edge cycle is not counted.
          if (rxs_d && !rxs) begin
            os_cnt    <= '0;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            state     <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            if (os_cnt == OS_HALF) begin
              os_cnt <= '0;
              if (!rxs) begin
                bit_cnt <= '0;
                par_acc <= 1'b0;
                state   <= S_DATA;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt     <= '0;
              shift_en   <= 1'b1;
              sample_bit <= rxs;
              shreg      <= {rxs, shreg[DATA_BITS-1:1]};
              par_acc    <= par_acc ^ rxs;
              if (bit_cnt == BIT_LAST) begin
                state <= par_en_q ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt    <= '0;
              par_err_q <= (par_acc ^ rxs) != par_odd_q;
              state     <= S_STOP;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (os_cnt == OS_LAST) begin
              // Leave at mid-stop-bit so a start bit right after it is caught.
              os_cnt       <= '0;
              data_valid   <= 1'b1;
              parity_error <= par_en_q & par_err_q;
              stop_error   <= ~rxs;
              rx_data      <= rxs ? shreg : '0;
              state        <= S_IDLE;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign checkparity = (state == S_PARITY);
  assign checkstop   = (state == S_STOP);
  assign state_dbg   = state;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Frame-sequencing controller for the UART receive path. Synchronises the serial input and detects the start bit using 16x oversampling. Samples each data, parity and stop bit at mid-bit, and drives the stage enables (`shift_en`, `checkparity`, `checkstop`) that the deserialiser, parity checker and stop-bit checker consume. Assembles the received byte and reports it with a one-cycle `data_valid` pulse plus parity and stop error flags.

## Interface
- `DATA_BITS`, 8, data bits per frame, 5..8, LSB first
- `OS_RATE`, 16, oversample ticks per bit, even, ≥ 8
- `clk` input 1: system clock; all logic is on its rising edge
- `reset` input 1: asynchronous, active-high
- `baud_tick` input 1: one-`clk` pulse at `OS_RATE`×baud; the FSM and counters advance only on it
- `rxin` input 1: raw serial line, idle high, asynchronous to `clk`
- `parity_en` input 1: frame carries a parity bit; sampled when leaving IDLE
- `parity_odd` input 1: 1 = odd parity, 0 = even; sampled when leaving IDLE
- `busy` output 1: high in every state other than IDLE
- `shift_en` output 1: one-`clk` pulse per data-bit sample
- `sample_bit` output 1: synchronised line value, valid when `shift_en` is high
- `checkparity` output 1: high while in PARITY
- `checkstop` output 1: high while in STOP
- `rx_data` output `DATA_BITS`: last received word; holds until the next `data_valid`
- `data_valid` output 1: one-`clk` pulse at frame end
- `parity_error` output 1: parity flag of the last frame; updated with `data_valid`
- `stop_error` output 1: stop flag of the last frame; updated with `data_valid`

## Operation
- **Input sync:** 2-flop synchroniser on `rxin`, giving `rxs` (2 `clk` latency). Both flops reset to 1. A third flop holds `rxs_d` for edge detection.
- **Counters:** `os_cnt` is `$clog2(OS_RATE)` bits; `bit_cnt` is `$clog2(DATA_BITS)` bits. Both wrap only by explicit clear, never by overflow.
- **IDLE:**
  - Falling edge (`rxs_d`=1, `rxs`=0) clears `os_cnt`, latches `parity_en`/`parity_odd`, then goes to START.
  - A line held low does not re-trigger; a 1 must be seen first.
  - This edge detection runs every `clk`, not only on ticks.
- **START:**
  - Each tick increments `os_cnt`.
  - On the tick where `os_cnt`==`OS_RATE/2-1`: if `rxs`=0, clear `os_cnt` and `bit_cnt` and go to DATA. If `rxs`=1 it is a false start: return to IDLE with no outputs affected.
- **Mid-bit sampling (DATA, PARITY, STOP):** each tick increments `os_cnt`. The tick where `os_cnt`==`OS_RATE-1` is the sample tick; it clears `os_cnt`.
- **DATA:**
  - Each sample tick pulses `shift_en`, shifts `rxs` into the internal shift register at the MSB end (LSB-first reception), accumulates XOR parity and increments `bit_cnt`.
  - After sample `DATA_BITS-1`: go to PARITY if latched `parity_en`, else STOP.
- **PARITY:** on the sample tick, compute error = (XOR of data ^ `rxs`) != latched `parity_odd`, store it, then go to STOP.
- **STOP:** on the sample tick, always return to IDLE at mid-stop-bit, so back-to-back frames are accepted. At the same time:
  - Pulse `data_valid`.
  - Load `parity_error` with the stored flag, or 0 if parity is disabled.
  - Load `stop_error` with `~rxs`.
  - Load `rx_data` with the shift register, or with 0 when `stop_error` is 1. A frame with a stop error delivers zero data.
- **Config changes:** `parity_en`/`parity_odd` changes mid-frame have no effect on the current frame.
- **Reset (any time, including mid-frame):**
  - State returns to IDLE; counters, shift register and parity accumulator clear.
  - All outputs go to 0: `busy`, `shift_en`, `checkparity`, `checkstop`, `rx_data`, `data_valid`, `parity_error`, `stop_error`.
  - A partial frame is discarded with no `data_valid`.

## Timing
- `shift_en`, `data_valid`, the error flag updates and `rx_data` are registered. They appear the `clk` after the qualifying tick edge; `shift_en` and `data_valid` last exactly 1 `clk`.
- `checkparity`/`checkstop` are decoded from state, so they change in the same cycle as the state register.
- **Start-edge latency:** `rxin` fall → `rxs` fall: 2 `clk`. START → DATA: after `OS_RATE/2` ticks.
- **Frame latency:** from the START→DATA transition to `data_valid` is (`DATA_BITS` + `parity_en` + 1)×`OS_RATE` ticks, +1 `clk`.
- `baud_tick` arriving on the same `clk` as the start edge does not count toward `os_cnt`.
- `busy` falls in the same cycle that `data_valid` rises.
- `data_valid` is never asserted two `clk` in a row.

## Test plan
- **Basic frame:** `OS_RATE`=16, `parity_en`=0, frame 0x A5 (start, bits 1,0,1,0,0,1,0,1, stop=1) → exactly 8 `shift_en` pulses; `data_valid` once; `rx_data`=0xA5, `parity_error`=0, `stop_error`=0.
- **Parity:** `parity_en`=1, `parity_odd`=0, 0x3C with parity bit 0 → `parity_error`=0. Repeat with parity bit 1 → `parity_error`=1, `rx_data`=0x3C; `checkparity` high for 16 ticks.
- **Bad stop bit:** 0x FF with stop bit 0 → `data_valid` pulse, `stop_error`=1, `rx_data`=0x00. Line held low afterwards → no new START until the line returns high and falls again.
- **False start:** 4-tick low glitch on `rxin` in IDLE → back to IDLE at tick 8; no `shift_en`, no `data_valid`, `busy` pulse only.
- **Back-to-back:** 0x12 then 0x34 with the next start bit immediately after the stop bit → two `data_valid` pulses, `rx_data` 0x12 then 0x34, no errors.
- **Reset mid-frame:** assert `reset` during data bit 4 → all outputs 0 asynchronously. After release, a clean 0x5A frame is received correctly.
